// File: rtl/iiitb_bc_pkg.sv
// Shared types and constants for the two-requester round-robin counter controller.
// Optional saturating counter mode is selected by defining BC_CTRL_SAT_EN.
package iiitb_bc_pkg;

  localparam int BC_WIDTH  = 4;
  localparam int BC_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 dir;
    logic [BC_STEP_W-1:0] steps;
  } cmd_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/iiitb_bc_core.sv
// WIDTH-bit up/down counter with synchronous reset; wraps by default and
// saturates at both ends when BC_CTRL_SAT_EN is defined.
module iiitb_bc_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
`ifdef BC_CTRL_SAT_EN
      if (up) begin
        if (count_q != {WIDTH{1'b1}}) count_q <= count_q + 1'b1;
      end else begin
        if (count_q != '0) count_q <= count_q - 1'b1;
      end
`else
      count_q <= up ? count_q + 1'b1 : count_q - 1'b1;
`endif
    end
  end

  assign count = count_q;

endmodule

// File: rtl/iiitb_bc_arb_ctrl.sv
// Round-robin grant of a shared up/down counter to two requesters; each command
// steps the counter N times, then pulses done to its owner. See BC_CTRL_SAT_EN in the core.
module iiitb_bc_arb_ctrl
  import iiitb_bc_pkg::*;
#(
  parameter int WIDTH  = BC_WIDTH,
  parameter int STEP_W = BC_STEP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_dir,
  input  logic [2*STEP_W-1:0] req_steps,
  output logic [1:0]          req_ready,
  output logic [1:0]          done,
  output logic                busy,
  output logic                owner,
  output logic                count_en,
  output logic                count_up,
  output logic [WIDTH-1:0]    count
);

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                owner_q, owner_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                grant_idx;
  cmd_t                sel_cmd;

  // The pointer names the preferred requester; fall back to the other one.
  always_comb begin
    grant_idx     = req_valid[rr_q] ? rr_q : ~rr_q;
    sel_cmd.dir   = req_dir[grant_idx];
    sel_cmd.steps = grant_idx ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    req_ready = 2'b00;
    done      = 2'b00;
    count_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_idx] = 1'b1;
          owner_d = grant_idx;
          dir_d   = sel_cmd.dir;
          rem_d   = sel_cmd.steps;
          state_d = (sel_cmd.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        count_en = 1'b1;
        rem_d    = rem_q - 1'b1;
        if (rem_q == STEP_W'(1)) state_d = DONE;
      end
      DONE: begin
        done[owner_q] = 1'b1;
        rr_d          = ~owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      dir_q   <= DIR_DOWN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign count_up = dir_q;

  iiitb_bc_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .up    (dir_q),
    .count (count)
  );

endmodule

// File: tb/tb_iiitb_bc_arb_ctrl.sv
// Directed bench for iiitb_bc_arb_ctrl: expected done/final-count records are queued at
// accept and popped when done pulses. Define BC_CTRL_SAT_EN to check saturating mode.
module tb_iiitb_bc_arb_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_dir;
  logic [7:0] req_steps;
  logic [1:0] req_ready;
  logic [1:0] done;
  logic       busy;
  logic       owner;
  logic       count_en;
  logic       count_up;
  logic [3:0] count;

  typedef struct packed {
    logic [1:0] done;
    logic [3:0] count;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_cnt = 4'd0;

  iiitb_bc_arb_ctrl #(.WIDTH(4), .STEP_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .owner     (owner),
    .count_en  (count_en),
    .count_up  (count_up),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] step(input logic [3:0] c, input logic up);
`ifdef BC_CTRL_SAT_EN
    if (up) return (c == 4'hF) ? c : c + 4'd1;
    return (c == 4'h0) ? c : c - 4'd1;
`else
    return up ? c + 4'd1 : c - 4'd1;
`endif
  endfunction

  // Drive one command on the lines in 'valids', expect requester r to win, then
  // track the run cycle by cycle and pop the scoreboard when done pulses.
  task automatic serve(input logic [1:0] valids, input int r, input logic dir, input int steps);
    logic [3:0] exp_cnt;
    int         w;
    exp_t       e;
    exp_cnt = model_cnt;
    @(negedge clk);
    req_valid = valids;
    req_dir   = {dir, dir};
    req_steps = {steps[3:0], steps[3:0]};
    #1;
    check("ready_grant", req_ready, 32'(2'b01 << r));
    check("ready_subset", req_ready & ~req_valid, 0);
    check("busy_idle", busy, 0);
    @(posedge clk);
    for (int i = 0; i < steps; i++) model_cnt = step(model_cnt, dir);
    e.done  = 2'(2'b01 << r);
    e.count = model_cnt;
    sb.push_back(e);
    @(negedge clk);
    req_valid[r] = 1'b0;
    for (int i = 0; i < steps; i++) begin
      check("run_en", count_en, 1);
      check("run_count", count, exp_cnt);
      check("run_busy", busy, 1);
      check("run_ready", req_ready, 0);
      check("run_dir", count_up, dir);
      check("run_done", done, 0);
      exp_cnt = step(exp_cnt, dir);
      @(negedge clk);
    end
    w = 0;
    while (done == 2'b00 && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("done_latency", w, 0);
    e = sb.pop_front();
    check("done_vec", done, e.done);
    check("done_count", count, e.count);
    check("done_owner", owner, r);
    check("done_en", count_en, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_cnt = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_dir = 2'b00;
    req_steps = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_en", count_en, 0);
    check("rst_up", count_up, 0);
    check("rst_owner", owner, 0);
    reset = 1'b0;

    // req0 up 3 from 0
    serve(2'b01, 0, 1'b1, 3);
    // climb to 14, then req1 up 3 across the top
    serve(2'b01, 0, 1'b1, 11);
    serve(2'b10, 1, 1'b1, 3);

    // down from 0
    do_reset();
    serve(2'b01, 0, 1'b0, 1);

    // contention right after reset: req0, req1, then req0 again
    do_reset();
    serve(2'b11, 0, 1'b1, 1);
    serve(2'b10, 1, 1'b1, 1);
    serve(2'b11, 0, 1'b1, 1);

    // zero-step command
    serve(2'b01, 0, 1'b1, 0);
    serve(2'b10, 1, 1'b0, 0);

    // reset in the second RUN cycle of a 5-step command
    @(negedge clk);
    req_valid = 2'b01;
    req_dir   = 2'b11;
    req_steps = 8'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    check("mid_run_count", count, model_cnt);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 4'd0;
    check("mid_busy", busy, 0);
    check("mid_count", count, 0);
    check("mid_done", done, 0);
    check("mid_en", count_en, 0);
    @(negedge clk);
    check("mid_done_after", done, 0);
    check("mid_count_hold", count, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
